fp16_result_sink: RTL

//  Receiving end of the FP16ALUArray result interface (out_valid/out). Captures each

---
 rtl/fp16_result_sink.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp16_result_sink.sv
// ---------------------------------------------------------------------------
// fp16_result_sink
//   Receiving end of the FP16 ALU array result interface. Each accepted
//   LANES x 16-bit result vector is queued in a small vector FIFO, then
//   serialised one lane per beat (lane 0 = most significant 16 bits) over a
//   valid/ready stream. A running 16-bit signature, an accepted-vector count
//   and a sticky overflow flag are kept alongside.
//
// Ports
//   clk_600m      clock
//   rst           synchronous reset, active-high
//   in_valid_i    result vector present (no backpressure towards the ALU)
//   in_data_i     result vector, lane i = in_data_i[(LANES-i)*16-1 -: 16]
//   stat_clr_i    pulse: clear signature, vec_count, overflow
//   m_valid_o     serial beat valid
//   m_ready_i     consumer accepts beat
//   m_data_o      lane value of current beat
//   m_lane_o      lane index of current beat
//   m_last_o      high on the beat of lane LANES-1
//   signature_o   running signature over accepted vectors
//   vec_count_o   accepted vectors since reset/clear (wraps)
//   overflow_o    sticky: a vector arrived while the FIFO was full
//   fifo_level_o  vectors held in the FIFO (shift register not counted)
// ---------------------------------------------------------------------------
module fp16_result_sink #(
    parameter int LANES = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_600m,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic [LANES*16-1:0]        in_data_i,
    input  logic                       stat_clr_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [15:0]                m_data_o,
    output logic [$clog2(LANES)-1:0]   m_lane_o,
    output logic                       m_last_o,
    output logic [15:0]                signature_o,
    output logic [31:0]                vec_count_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o
);

    localparam int VW = LANES * 16;
    localparam int LW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [LW-1:0] LANE_ZERO = {LW{1'b0}};
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // XOR-fold of all lanes of a vector; feeds the signature.
    function automatic logic [15:0] xor_lanes(input logic [VW-1:0] vec);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < LANES; i++) begin
            acc = acc ^ vec[i*16 +: 16];
        end
        return acc;
    endfunction

    // Storage and state
    logic [VW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q,  level_d;

    state_t        state_q,  state_d;
    logic          valid_q,  valid_d;
    logic [LW-1:0] lane_q,   lane_d;
    logic          last_q,   last_d;
    logic [VW-1:0] sh_q,     sh_d;

    logic [15:0]   sig_q,    sig_d;
    logic [31:0]   cnt_q,    cnt_d;
    logic          ovf_q,    ovf_d;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [VW-1:0] head_s;
    logic [LW-1:0] lane_inc_s;
    logic [15:0]   lane_xor_s;

    assign empty_s    = (level_q == {CW{1'b0}});
    assign full_s     = (level_q == FULL_LVL);
    assign head_s     = mem_q[rd_ptr_q];
    assign lane_inc_s = lane_q + {{(LW-1){1'b0}}, 1'b1};

    // Serialiser FSM: loads a vector from the FIFO head and steps through lanes.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        lane_d  = lane_q;
        last_d  = last_q;
        sh_d    = sh_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sh_d    = head_s;
                    lane_d  = LANE_ZERO;
                    last_d  = (LAST_LANE == LANE_ZERO);
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (m_ready_i) begin
                    if (last_q) begin
                        // Back-to-back vectors: reload without a bubble.
                        if (!empty_s) begin
                            pop_s   = 1'b1;
                            sh_d    = head_s;
                            lane_d  = LANE_ZERO;
                            last_d  = (LAST_LANE == LANE_ZERO);
                            valid_d = 1'b1;
                        end else begin
                            sh_d    = {VW{1'b0}};
                            lane_d  = LANE_ZERO;
                            last_d  = 1'b0;
                            valid_d = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sh_d   = {sh_q[VW-17:0], 16'h0000};
                        lane_d = lane_inc_s;
                        last_d = (lane_inc_s == LAST_LANE);
                    end
                end else begin
                    // Beat stalled: everything holds.
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                lane_d  = LANE_ZERO;
                last_d  = 1'b0;
                sh_d    = {VW{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping and statistics next-state.
    always_comb begin
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push_s     = in_valid_i && (!full_s || pop_s);
        drop_s     = in_valid_i && full_s && !pop_s;
        lane_xor_s = xor_lanes(in_data_i);

        wr_ptr_d = push_s ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
        level_d  = level_q + CW'(push_s) - CW'(pop_s);

        if (stat_clr_i) begin
            // Clear wins, but a same-cycle vector seeds the fresh statistics.
            sig_d = push_s ? lane_xor_s : 16'h0000;
            cnt_d = push_s ? 32'd1 : 32'd0;
            ovf_d = drop_s;
        end else begin
            sig_d = push_s ? ({sig_q[14:0], sig_q[15]} ^ lane_xor_s) : sig_q;
            cnt_d = push_s ? (cnt_q + 32'd1) : cnt_q;
            ovf_d = ovf_q | drop_s;
        end
    end

    // Control, serialiser and statistics registers.
    always_ff @(posedge clk_600m) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {CW{1'b0}};
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            lane_q   <= LANE_ZERO;
            last_q   <= 1'b0;
            sh_q     <= {VW{1'b0}};
            sig_q    <= 16'h0000;
            cnt_q    <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            lane_q   <= lane_d;
            last_q   <= last_d;
            sh_q     <= sh_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Vector storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_600m) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign m_valid_o    = valid_q;
    assign m_data_o     = sh_q[VW-1 -: 16];
    assign m_lane_o     = lane_q;
    assign m_last_o     = last_q;
    assign signature_o  = sig_q;
    assign vec_count_o  = cnt_q;
    assign overflow_o   = ovf_q;
    assign fifo_level_o = level_q;

endmodule
